counter_sequence_checker: RTL

Monitor-side counterpart of the binary counter: observes a counter's output stream and checks it increments by exactly one per valid sample, modulo 2^WIDTH. It locks onto the stream, flags each step error, keeps a saturating error count and raises a sticky fault. It is instantiated next to a counter DUT in generated benches, or on-chip as a self-check.

---
 rtl/counter_chk_pkg.sv | 23 ++
 rtl/sat_counter.sv | 23 ++
 rtl/counter_sequence_checker.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/counter_chk_pkg.sv
// Shared types and defaults for the counter sequence checker.
// next_count gives the modulo-2^width successor of an observed count.
package counter_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 6;
  localparam int DEF_ERR_W    = 8;
  localparam int DEF_LOCK_LEN = 2;
  localparam int DEF_MAX_ERRS = 4;

  function automatic logic [31:0] next_count(input logic [31:0] value, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the error total. When clr and inc arrive
// together the clear applies and that cycle's increment still counts.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= inc ? W'(1) : '0;
    end else if (inc && !(&value)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/counter_sequence_checker.sv
// Watches a counter's output stream and checks it steps by one per valid sample,
// locking first, then counting step errors up to a sticky fault.
//
// state | meaning
// IDLE  | checker disabled, samples ignored
// SYNC  | hunting for LOCK_LEN consecutive +1 steps, no errors counted
// TRACK | locked, every valid sample compared against expected
// FAULT | error limit reached, samples ignored until clr_err
module counter_sequence_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ERR_W    = DEF_ERR_W,
  parameter int LOCK_LEN = DEF_LOCK_LEN,
  parameter int MAX_ERRS = DEF_MAX_ERRS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_count,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             fault,
  output logic [WIDTH-1:0] expected
);

  localparam int MW = $clog2(LOCK_LEN + 1);

  state_t           state, state_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [WIDTH-1:0] ref_val, ref_nx, expected_nx;
  logic [WIDTH-1:0] obs_plus1, ref_plus1;
  logic             have_ref, have_ref_nx;
  logic             locked_nx, mismatch_nx, fault_nx;
  logic             step_bad, sync_lock, hit_max;
  logic [ERR_W-1:0] err_after;

  assign obs_plus1 = WIDTH'(next_count(32'(obs_count), WIDTH));
  assign ref_plus1 = WIDTH'(next_count(32'(ref_val), WIDTH));

  assign step_bad  = chk_en && (state == TRACK) && obs_valid && (obs_count != expected);
  assign sync_lock = chk_en && (state == SYNC) && obs_valid && have_ref &&
                     (obs_count == ref_plus1) && ((match_cnt + MW'(1)) == MW'(LOCK_LEN));

  // Error total as it will stand after this cycle's mismatch, used to spot the fault edge
  assign err_after = clr_err ? ERR_W'(1) : ((&err_count) ? err_count : err_count + ERR_W'(1));
  assign hit_max   = step_bad && (32'(err_after) >= MAX_ERRS);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (step_bad),
    .clr   (clr_err),
    .value (err_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      match_cnt <= '0;
      ref_val   <= '0;
      have_ref  <= 1'b0;
      expected  <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
      ref_val   <= ref_nx;
      have_ref  <= have_ref_nx;
      expected  <= expected_nx;
      locked    <= locked_nx;
      mismatch  <= mismatch_nx;
      fault     <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!chk_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = SYNC;
        SYNC:    if (sync_lock) state_nx = TRACK;
        TRACK:   if (hit_max) state_nx = FAULT;
        FAULT:   if (clr_err) state_nx = SYNC;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    match_nx    = match_cnt;
    ref_nx      = ref_val;
    have_ref_nx = have_ref;
    expected_nx = expected;
    locked_nx   = locked;
    mismatch_nx = 1'b0;
    fault_nx    = hit_max ? 1'b1 : (clr_err ? 1'b0 : fault);
    if (!chk_en) begin
      locked_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          match_nx    = '0;
          have_ref_nx = 1'b0;
          locked_nx   = 1'b0;
        end
        SYNC: begin
          if (obs_valid) begin
            ref_nx      = obs_count;
            have_ref_nx = 1'b1;
            if (have_ref) begin
              match_nx = (obs_count == ref_plus1) ? match_cnt + MW'(1) : '0;
            end
            if (sync_lock) begin
              locked_nx   = 1'b1;
              expected_nx = obs_plus1;
              match_nx    = '0;
            end
          end
        end
        TRACK: begin
          // A good sample advances expected; a bad one resyncs to the sample
          if (obs_valid) expected_nx = obs_plus1;
          mismatch_nx = step_bad;
          if (hit_max) locked_nx = 1'b0;
        end
        FAULT: begin
          locked_nx = 1'b0;
          if (clr_err) begin
            match_nx    = '0;
            have_ref_nx = 1'b0;
          end
        end
        default: locked_nx = 1'b0;
      endcase
    end
  end

endmodule
